// File: rtl/reg_file_sb.sv
// reg_file_sb: integer register file with a 1-cycle registered read path and
// a per-register scoreboard of pending writes.
//
// After reset a sweep writes zero into one array entry per cycle, so reset
// never has to reach the storage bits. All requests are ignored until the
// sweep has finished and o_ready is high.
//
// Optional feature macro: RF_BYPASS_EN
//   defined   - a read that coincides with a valid same-cycle write to the
//               same index returns the new data and the post-write busy flag.
//   undefined - such a read returns the old array value and old busy flag.
//
// Handshake: there is no backpressure. i_rd_en, i_issue_en and i_reg_write
// are single-cycle strobes, accepted on any rising edge while o_ready is
// high. o_rd_valid is high for exactly one cycle, one edge after each
// accepted i_rd_en. The read data and busy outputs hold their last values
// while o_rd_valid is low.
//
// dbg_state exposes the FSM state (0 = INIT sweep, 1 = RUN).

module reg_file_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_ready,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rs1,
  input  logic [AW-1:0]    i_rs2,
  output logic             o_rd_valid,
  output logic [XLEN-1:0]  o_read_data1,
  output logic [XLEN-1:0]  o_read_data2,
  output logic             o_rs1_busy,
  output logic             o_rs2_busy,
  input  logic             i_issue_en,
  input  logic [AW-1:0]    i_issue_rd,
  input  logic             i_reg_write,
  input  logic [AW-1:0]    i_rd,
  input  logic [XLEN-1:0]  i_write_data,
  output logic [NREGS-1:0] o_pending,
  output logic             dbg_state
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_t            state;
  state_t            state_next;
  logic [AW-1:0]     sweep_cnt;
  logic              sweep_we;
  logic              run;
  logic [XLEN-1:0]   mem [NREGS];

  logic              wr_ok;
  logic              iss_ok;
  logic              fwd1;
  logic              fwd2;
  logic [XLEN-1:0]   rd_data1;
  logic [XLEN-1:0]   rd_data2;
  logic              rd_busy1;
  logic              rd_busy2;
  logic [NREGS-1:0]  pending_next;

  // An index is architecturally addressable when it is in range and is not
  // the hardwired zero register.
  function automatic logic idx_ok(input logic [AW-1:0] idx);
    return (32'(idx) < 32'(NREGS)) && !((ZERO_REG != 0) && (idx == '0));
  endfunction

  // State register: restart the sweep on every reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= INIT;
    else       state <= state_next;
  end

  // Next state: leave INIT after the last entry has been zeroed.
  always_comb begin
    state_next = state;
    if ((state == INIT) && (sweep_cnt == LAST_IDX)) state_next = RUN;
  end

  // FSM outputs: ready in RUN, sweep writes in INIT.
  always_comb begin
    run       = (state == RUN);
    o_ready   = run;
    sweep_we  = (state == INIT);
    dbg_state = state;
  end

  // Sweep counter walks 0..NREGS-1 once per INIT pass.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sweep_cnt <= '0;
    end else if (state == INIT) begin
      sweep_cnt <= (sweep_cnt == LAST_IDX) ? '0 : sweep_cnt + AW'(1);
    end
  end

  assign wr_ok  = run && i_reg_write && idx_ok(i_rd);
  assign iss_ok = run && i_issue_en && idx_ok(i_issue_rd);

`ifdef RF_BYPASS_EN
  assign fwd1 = wr_ok && (i_rd == i_rs1);
  assign fwd2 = wr_ok && (i_rd == i_rs2);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  // Storage array: sweep zeroes during INIT, writeback during RUN.
  always_ff @(posedge i_clk) begin
    if (sweep_we)   mem[sweep_cnt] <= '0;
    else if (wr_ok) mem[i_rd]      <= i_write_data;
  end

  // Scoreboard update: writeback clears, issue sets; issue applied last so a
  // new producer wins over a retiring one on the same index.
  always_comb begin
    pending_next = o_pending;
    if (wr_ok)  pending_next[i_rd]       = 1'b0;
    if (iss_ok) pending_next[i_issue_rd] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_pending <= '0;
    else       o_pending <= pending_next;
  end

  // Read-port selection: zero for invalid indices, forwarded write data when
  // bypass applies, otherwise the array and current scoreboard.
  always_comb begin
    rd_data1 = '0;
    rd_busy1 = 1'b0;
    rd_data2 = '0;
    rd_busy2 = 1'b0;
    if (idx_ok(i_rs1)) begin
      if (fwd1) begin
        rd_data1 = i_write_data;
        rd_busy1 = iss_ok && (i_issue_rd == i_rs1);
      end else begin
        rd_data1 = mem[i_rs1];
        rd_busy1 = o_pending[i_rs1];
      end
    end
    if (idx_ok(i_rs2)) begin
      if (fwd2) begin
        rd_data2 = i_write_data;
        rd_busy2 = iss_ok && (i_issue_rd == i_rs2);
      end else begin
        rd_data2 = mem[i_rs2];
        rd_busy2 = o_pending[i_rs2];
      end
    end
  end

  // Registered read outputs; data and busy hold when no read is accepted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rd_valid   <= 1'b0;
      o_read_data1 <= '0;
      o_read_data2 <= '0;
      o_rs1_busy   <= 1'b0;
      o_rs2_busy   <= 1'b0;
    end else begin
      o_rd_valid <= run && i_rd_en;
      if (run && i_rd_en) begin
        o_read_data1 <= rd_data1;
        o_read_data2 <= rd_data2;
        o_rs1_busy   <= rd_busy1;
        o_rs2_busy   <= rd_busy2;
      end
    end
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised integer register file with a registered (1-cycle) read path and a per-register scoreboard of pending writes, for the pipelined core. After reset, a built-in sweep zero-initialises the array one entry per cycle, so reset does not have to fan out to every storage bit. Decode uses the read ports and busy flags. Issue marks destinations pending. Writeback writes data and clears pending.

Parameters:
XLEN, 32, data width of every register
NREGS, 32, number of architectural registers (2..64, need not be power of 2)
ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes and is never pending
AW, $clog2(NREGS), derived localparam: register index width (not overridable)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous, active-high reset
o_ready  out  1  high once init sweep done; all requests ignored while low
i_rd_en  in  1  read request for i_rs1/i_rs2 this cycle
i_rs1  in  AW  read index 1
i_rs2  in  AW  read index 2
o_rd_valid  out  1  read result valid (1 cycle after i_rd_en)
o_read_data1  out  XLEN  data for rs1
o_read_data2  out  XLEN  data for rs2
o_rs1_busy  out  1  rs1 had a pending write when sampled
o_rs2_busy  out  1  rs2 had a pending write when sampled
i_issue_en  in  1  mark i_issue_rd pending
i_issue_rd  in  AW  destination being issued
i_reg_write  in  1  writeback strobe
i_rd  in  AW  writeback index
i_write_data  in  XLEN  writeback data
o_pending  out  NREGS  live scoreboard, bit n = register n pending

Behaviour:
- Reset (async assert, any state): state=INIT, sweep counter=0, o_ready=0, o_rd_valid=0, o_read_data1/2=0, o_rs1/2_busy=0, o_pending=all 0. Array contents are not reset directly.
- INIT: each cycle write 0 to entry[counter], then counter++. After entry NREGS-1 is written, state goes to RUN. o_ready=1 from the first RUN cycle, which is NREGS cycles after reset deasserts. i_rd_en, i_issue_en and i_reg_write are ignored in INIT. Reset during INIT restarts the sweep at 0.
- RUN, read: o_rd_valid <= i_rd_en. When i_rd_en=1, register data and busy flags for rs1/rs2 on the same edge. When i_rd_en=0, hold data and busy; only o_rd_valid drops.
- Read of index 0 with ZERO_REG=1 returns 0, busy=0. Any index >= NREGS returns data 0, busy 0.
- Write: when i_reg_write=1 and i_rd is valid (and nonzero if ZERO_REG=1), entry[i_rd] <= i_write_data and pending[i_rd] <= 0. Otherwise the write is dropped.
- Issue: when i_issue_en=1 and i_issue_rd is valid (and nonzero if ZERO_REG=1), pending[i_issue_rd] <= 1.
- Issue and write to the same index in one cycle: issue wins, so pending stays 1 (new producer). Data is still written.
- Read and write to the same index in one cycle: behaviour depends on RF_BYPASS_EN (see Optional Feature).
- rs1==rs2 is legal; both ports return identical data and busy.
- No other state. No X is ever driven after reset.

Optional Feature:
RF_BYPASS_EN
- Defined: a read that coincides with a same-cycle valid write to the same index returns i_write_data. The busy flag reflects post-write scoreboard state: 0, unless the same index is also issued that cycle, in which case 1.
- Undefined: such a read returns the old array value and the pre-write busy flag.
- Zero-register and out-of-range rules apply in both cases.

Test Plan:
- Release reset with NREGS=32 -> o_ready low for exactly 32 cycles, then high. Read every index -> 0x00000000, busy 0, o_pending=0.
- Write x5=0xDEADBEEF, next cycle read rs1=5, rs2=0 -> one cycle later o_rd_valid=1, data1=0xDEADBEEF, data2=0. Write x0=0x1234 then read x0 -> 0.
- Issue x7, read rs1=7 -> busy1=1, o_pending[7]=1. Writeback x7=0x55 -> o_pending[7]=0; a later read gives 0x55 with busy 0.
- Same-cycle issue x9 and write x9=0xAA -> o_pending[9]=1, and a later read returns 0xAA with busy 1.
- Same-cycle write x3=0x77 and read rs1=3 (x3 previously 0x11) -> data1=0x77 with RF_BYPASS_EN, 0x11 without.
- Assert i_rst at sweep cycle 10 while issuing/writing -> outputs 0 immediately. After release, o_ready returns exactly NREGS cycles later and all registers read 0.
